// File: rtl/inert_intf.sv
// Inertial interface: configures the IMU over the SPI master, then on each
// data-ready interrupt reads raw pitch rate and Z acceleration and presents
// both words together with a single-cycle vld strobe.
module inert_intf #(
    parameter int INIT_WAIT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic        init_done
);

    typedef enum logic [2:0] {
        S_INIT_WAIT,
        S_CFG,
        S_CFG_WT,
        S_IDLE,
        S_RD,
        S_RD_WT
    } state_t;

    // Configuration writes, issued in order once after power-up wait
    localparam logic [15:0] CFG_CMDS [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    // Reads: pitch low, pitch high, AZ low, AZ high
    localparam logic [15:0] RD_CMDS  [4] = '{16'hA400, 16'hA500, 16'hAC00, 16'hAD00};

    state_t                 state_reg;
    logic [1:0]             idx_reg;
    logic [INIT_WAIT_W-1:0] wait_cnt_reg;
    logic [2:0]             int_sync_reg;
    logic                   pend_reg;
    logic [7:0]             ptch_l_reg;
    logic [7:0]             ptch_h_reg;
    logic [7:0]             az_l_reg;
    logic                   wrt_reg;
    logic [15:0]            cmd_reg;
    logic                   vld_reg;
    logic [15:0]            ptch_rt_reg;
    logic [15:0]            az_reg;
    logic                   init_done_reg;

    logic int_rise;
    logic rd_start;

    // Only the low response byte carries data
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:8];

    // Bits [1:0] are the synchronizer, bit [2] is the edge-detect history
    assign int_rise = int_sync_reg[1] & ~int_sync_reg[2];
    // The read sequence starts (and consumes the pending event) from IDLE only
    assign rd_start = (state_reg == S_IDLE) && pend_reg;

    // Synchronize the asynchronous interrupt and keep one flop of history
    always_ff @(posedge clk) begin
        if (rst)
            int_sync_reg <= 3'b000;
        else
            int_sync_reg <= {int_sync_reg[1:0], INT};
    end

    // Pending interrupt; a fresh edge wins over the clear so it is never lost
    always_ff @(posedge clk) begin
        if (rst)
            pend_reg <= 1'b0;
        else if (int_rise)
            pend_reg <= 1'b1;
        else if (rd_start)
            pend_reg <= 1'b0;
    end

    // Main sequencer: power-up wait, configuration, then interrupt-driven reads
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_INIT_WAIT;
            idx_reg       <= 2'd0;
            wait_cnt_reg  <= '0;
            ptch_l_reg    <= 8'h00;
            ptch_h_reg    <= 8'h00;
            az_l_reg      <= 8'h00;
            wrt_reg       <= 1'b0;
            cmd_reg       <= 16'h0000;
            vld_reg       <= 1'b0;
            ptch_rt_reg   <= 16'h0000;
            az_reg        <= 16'h0000;
            init_done_reg <= 1'b0;
        end else begin
            wrt_reg <= 1'b0;
            vld_reg <= 1'b0;
            case (state_reg)
                S_INIT_WAIT: begin
                    // The first write leaves on the edge that sees a full counter
                    if (&wait_cnt_reg) begin
                        wrt_reg   <= 1'b1;
                        cmd_reg   <= CFG_CMDS[0];
                        idx_reg   <= 2'd0;
                        state_reg <= S_CFG_WT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                S_CFG: begin
                    wrt_reg   <= 1'b1;
                    cmd_reg   <= CFG_CMDS[idx_reg];
                    state_reg <= S_CFG_WT;
                end
                S_CFG_WT: begin
                    if (done) begin
                        if (idx_reg == 2'd3) begin
                            init_done_reg <= 1'b1;
                            idx_reg       <= 2'd0;
                            state_reg     <= S_IDLE;
                        end else begin
                            idx_reg   <= idx_reg + 2'd1;
                            state_reg <= S_CFG;
                        end
                    end
                end
                S_IDLE: begin
                    // Issue the first read directly to keep interrupt latency short
                    if (pend_reg) begin
                        wrt_reg   <= 1'b1;
                        cmd_reg   <= RD_CMDS[0];
                        idx_reg   <= 2'd0;
                        state_reg <= S_RD_WT;
                    end
                end
                S_RD: begin
                    wrt_reg   <= 1'b1;
                    cmd_reg   <= RD_CMDS[idx_reg];
                    state_reg <= S_RD_WT;
                end
                S_RD_WT: begin
                    if (done) begin
                        idx_reg <= idx_reg + 2'd1;
                        case (idx_reg)
                            2'd0: begin
                                ptch_l_reg <= rd_data[7:0];
                                state_reg  <= S_RD;
                            end
                            2'd1: begin
                                ptch_h_reg <= rd_data[7:0];
                                state_reg  <= S_RD;
                            end
                            2'd2: begin
                                az_l_reg   <= rd_data[7:0];
                                state_reg  <= S_RD;
                            end
                            default: begin
                                // Last byte goes straight to the output so both
                                // words and vld update on the same edge
                                ptch_rt_reg <= {ptch_h_reg, ptch_l_reg};
                                az_reg      <= {rd_data[7:0], az_l_reg};
                                vld_reg     <= 1'b1;
                                state_reg   <= S_IDLE;
                            end
                        endcase
                    end
                end
                default: state_reg <= S_INIT_WAIT;
            endcase
        end
    end

    assign wrt       = wrt_reg;
    assign cmd       = cmd_reg;
    assign vld       = vld_reg;
    assign ptch_rt   = ptch_rt_reg;
    assign AZ        = az_reg;
    assign init_done = init_done_reg;

endmodule

// File: tb/tb_inert_intf.sv
// Bench for inert_intf: SPI slave model with a register-read view of the IMU,
// scoreboard of expected samples, and a monitor that checks every vld.
module tb_inert_intf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        INT = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt;
    logic [15:0] cmd;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;
    logic        init_done;

    inert_intf #(.INIT_WAIT_W(4)) dut (
        .clk(clk), .rst(rst), .INT(INT), .done(done), .rd_data(rd_data),
        .wrt(wrt), .cmd(cmd), .vld(vld), .ptch_rt(ptch_rt), .AZ(AZ),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Cycle number: count of rising edges since reset was released
    int cyc = 0;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Required command stream after reset: four config writes, then reads repeating
    function automatic logic [15:0] exp_cmd(input int p);
        logic [15:0] tbl [8];
        tbl = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460,
                16'hA400, 16'hA500, 16'hAC00, 16'hAD00};
        return (p < 4) ? tbl[p] : tbl[4 + ((p - 4) % 4)];
    endfunction

    typedef struct {
        logic [15:0] p;
        logic [15:0] a;
        int          at;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] fixed_q[$];

    // SPI model state
    int         pos = 0;
    int         busy = 0;
    int         cnt = 0;
    logic [15:0] cur_cmd = 16'h0;
    logic [7:0] rbytes [4];
    int         first_wrt_cyc = -1;
    int         exp_rd_wrt_cyc = -1;
    int         exp_init_cyc = -1;
    int         wrt_count = 0;
    int         rd_done_cnt = 0;
    bit         inject_spur = 0;
    int         vld_count = 0;

    // SPI slave: done 20 cycles after wrt; reads return bytes that feed the scoreboard
    initial begin
        logic [7:0] bt;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 0; done = 1'b0; pos = 0; first_wrt_cyc = -1; rd_done_cnt = 0;
            end else begin
                if (done) check("wrt_with_done", {31'd0, wrt}, 32'd0);
                done = 1'b0;
                if (busy != 0) begin
                    check("wrt_overlap", {31'd0, wrt}, 32'd0);
                    check("cmd_stable", {16'd0, cmd}, {16'd0, cur_cmd});
                    cnt--;
                    if (cnt == 0) begin
                        busy = 0;
                        done = 1'b1;
                        if (cur_cmd[15]) begin
                            bt = (fixed_q.size() > 0) ? fixed_q.pop_front() : 8'($urandom_range(0, 255));
                            rd_data = {8'($urandom), bt};
                            case (cur_cmd[15:8])
                                8'hA4: begin rbytes[0] = bt; rd_done_cnt = 1; end
                                8'hA5: begin rbytes[1] = bt; rd_done_cnt++; end
                                8'hAC: begin rbytes[2] = bt; rd_done_cnt++; end
                                default: begin
                                    rbytes[3] = bt; rd_done_cnt++;
                                    e.p = {rbytes[1], rbytes[0]};
                                    e.a = {rbytes[3], rbytes[2]};
                                    e.at = cyc + 1;
                                    sb_q.push_back(e);
                                end
                            endcase
                        end else begin
                            rd_data = 16'($urandom);
                            if (cur_cmd == 16'h1460) exp_init_cyc = cyc + 1;
                        end
                    end
                end else if (wrt) begin
                    check("cmd_order", {16'd0, cmd}, {16'd0, exp_cmd(pos)});
                    if (pos == 0) first_wrt_cyc = cyc;
                    if (cmd == 16'hA400 && exp_rd_wrt_cyc >= 0) begin
                        check("int_to_wrt_latency", cyc, exp_rd_wrt_cyc);
                        exp_rd_wrt_cyc = -1;
                    end
                    $display("spi wrt cmd=0x%04h cycle=%0d", cmd, cyc);
                    pos++; cur_cmd = cmd; busy = 1; cnt = 20; wrt_count++;
                end else if (inject_spur) begin
                    done = 1'b1;
                    rd_data = 16'($urandom);
                    inject_spur = 0;
                end
            end
        end
    end

    // Monitor: every vld pops the scoreboard; init_done rise time is checked
    initial begin
        logic init_prev = 1'b0;
        logic vld_prev = 1'b0;
        logic [15:0] hold_p = 16'h0;
        logic [15:0] hold_a = 16'h0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (init_done && !init_prev)
                    check("init_done_cycle", cyc, exp_init_cyc);
                if (vld) begin
                    check("vld_width", {31'd0, vld_prev}, 32'd0);
                    check("vld_after_init", {31'd0, init_done}, 32'd1);
                    if (sb_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL vld_unexpected: got vld=1, required no sample (cycle %0d)", cyc);
                    end else begin
                        e = sb_q.pop_front();
                        check("ptch_rt", {16'd0, ptch_rt}, {16'd0, e.p});
                        check("AZ", {16'd0, AZ}, {16'd0, e.a});
                        check("vld_cycle", cyc, e.at);
                    end
                    vld_count++;
                    $display("vld ptch_rt=0x%04h AZ=0x%04h cycle=%0d", ptch_rt, AZ, cyc);
                end else if (ptch_rt !== hold_p || AZ !== hold_a) begin
                    n_checks++; n_fail++;
                    $display("FAIL output_hold: got 0x%04h/0x%04h, required 0x%04h/0x%04h", ptch_rt, AZ, hold_p, hold_a);
                end
            end
            init_prev = init_done; vld_prev = vld; hold_p = ptch_rt; hold_a = AZ;
        end
    end

    task automatic pulse_int(input bit lat);
        @(negedge clk); #1;
        INT = 1'b1;
        if (lat) exp_rd_wrt_cyc = cyc + 4;
        repeat (3) @(negedge clk);
        #1 INT = 1'b0;
    endtask

    task automatic wait_init(input int lim);
        for (int i = 0; i < lim && !init_done; i++) begin
            @(negedge clk); #2;
        end
        check("init_done_timeout", {31'd0, init_done}, 32'd1);
    endtask

    task automatic wait_vld(input int n, input int lim);
        for (int i = 0; i < lim && vld_count < n; i++) begin
            @(negedge clk); #2;
        end
        check("vld_timeout", vld_count >= n, 1);
    endtask

    task automatic check_zero_outputs();
        check("rst_wrt", {31'd0, wrt}, 32'd0);
        check("rst_cmd", {16'd0, cmd}, 32'd0);
        check("rst_vld", {31'd0, vld}, 32'd0);
        check("rst_ptch_rt", {16'd0, ptch_rt}, 32'd0);
        check("rst_AZ", {16'd0, AZ}, 32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
    endtask

    initial begin
        logic [15:0] sp, sa;
        int wc, vc;

        // Reset state and power-up configuration
        repeat (3) @(negedge clk);
        check_zero_outputs();
        #1 rst = 1'b0;
        wait_init(500);
        check("first_wrt_cycle", first_wrt_cyc, 16);
        check("no_vld_during_init", vld_count, 0);

        // One read with known bytes
        fixed_q = '{8'h34, 8'h12, 8'h78, 8'h56};
        pulse_int(1);
        wait_vld(1, 300);
        check("ptch_fixed", {16'd0, ptch_rt}, 32'h1234);
        check("AZ_fixed", {16'd0, AZ}, 32'h5678);

        // Two interrupt edges during a read merge into one further sequence
        repeat (5) @(negedge clk);
        pulse_int(1);
        repeat (30) @(negedge clk);
        pulse_int(0);
        repeat (10) @(negedge clk);
        pulse_int(0);
        wait_vld(3, 600);
        repeat (150) @(negedge clk);
        check("vld_total_after_toggles", vld_count, 3);
        check("scoreboard_drained", sb_q.size(), 0);

        // Spurious done while idle
        sp = ptch_rt; sa = AZ; wc = wrt_count; vc = vld_count;
        @(negedge clk); #1 inject_spur = 1;
        repeat (10) @(negedge clk);
        check("spur_ptch_rt", {16'd0, ptch_rt}, {16'd0, sp});
        check("spur_AZ", {16'd0, AZ}, {16'd0, sa});
        check("spur_no_wrt", wrt_count, wc);
        check("spur_no_vld", vld_count, vc);
        pulse_int(1);
        wait_vld(vc + 1, 300);

        // Reset after the second read's done abandons the sequence
        vc = vld_count;
        pulse_int(1);
        for (int i = 0; i < 300 && rd_done_cnt != 2; i++) begin
            @(negedge clk); #2;
        end
        check("second_read_done_seen", rd_done_cnt, 2);
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check_zero_outputs();
        #1 rst = 1'b0;

        // Interrupt before init_done is serviced only after configuration
        repeat (5) @(negedge clk);
        pulse_int(0);
        wait_init(500);
        check("first_wrt_cycle_rerun", first_wrt_cyc, 16);
        check("no_vld_before_reinit", vld_count, vc);
        wait_vld(vc + 1, 300);
        repeat (150) @(negedge clk);
        check("one_read_after_early_int", vld_count, vc + 1);
        check("scoreboard_empty_end", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish within 20000 cycles");
        $fatal(1, "timeout");
    end

endmodule
